qspi_master_ctrl: RTL and testbench

Quad-SPI master controller. It consumes the command-side request bus (start, opcode, address, write_data, burst_len) and drives the flash pins CS, SCLK and IO[3:0].
- Frame layout: opcode on a single lane, address on four lanes, then optional quad write data, or dummy cycles followed by quad read data.
- Placement: it is the DUT behind the bench request interface.
- Pins: IO tristate resolution is done in the top wrapper from io_o/io_oe/io_i.

---
 rtl/qspi_pkg.sv | 18 +
 rtl/qspi_sclk_gen.sv | 45 ++++
 rtl/qspi_master_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_qspi_master_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// qspi_pkg: shared constants and types for the quad-SPI master.
//   OP_QPP / OP_QIOR : opcodes that select write / read frames; any other
//                      opcode produces a command-only frame.
//   OE_*             : io_oe patterns for single-lane, quad and released bus.
//   qspi_state_e     : frame-sequencing states.
package qspi_pkg;
   localparam logic [7:0] OP_QPP  = 8'h38;
   localparam logic [7:0] OP_QIOR = 8'hEB;

   localparam logic [3:0] OE_NONE   = 4'b0000;
   localparam logic [3:0] OE_SINGLE = 4'b0001;
   localparam logic [3:0] OE_QUAD   = 4'b1111;

   localparam int CMD_PERIODS  = 8;
   localparam int ADDR_PERIODS = 6;

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, CS_HOLD} qspi_state_e;
endpackage

// File: rtl/qspi_sclk_gen.sv
// qspi_sclk_gen: SCLK divider. While run=1 each SCLK half-period lasts
// CLK_DIV clk, starting with the low phase; run=0 parks SCLK low.
//   clk, reset_n : clock, synchronous active-low reset
//   run          : enable
//   sclk         : registered serial clock
//   low_start    : next edge starts a new low phase (period boundary)
//   rise         : next edge drives SCLK 0->1 (input sample edge)
//   pre_low      : next cycle is the last clk before a period boundary
module qspi_sclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   output logic sclk,
   output logic low_start,
   output logic rise,
   output logic pre_low
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] PRE  = CW'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!reset_n || !run) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else if (wrap) begin
         cnt  <= '0;
         sclk <= ~sclk;
      end else begin
         cnt  <= cnt + CW'(1);
      end
   end

   assign rise      = run && wrap && !sclk;
   assign low_start = run && wrap && sclk;
   // With a one-clk half period the cycle before the boundary is the low phase.
   assign pre_low   = run && ((CLK_DIV == 1) ? !sclk : (sclk && (cnt == PRE)));
endmodule

// File: rtl/qspi_master_ctrl.sv
// qspi_master_ctrl: quad-SPI master. Frame = opcode on IO[0], 24-bit address
// on four lanes, then quad write data (QPP) or dummy periods + quad read data
// (QIOR); other opcodes are command-only. All outputs are registered.
//   clk, reset_n          : clock, synchronous active-low reset
//   start, opcode, address, write_data, burst_len : request (accepted in IDLE)
//   wr_req                : asks for the next write byte, sampled same edge
//   busy, done            : frame in progress / one-clk completion pulse
//   rd_data, rd_valid     : received byte and its strobe
//   CS, SCLK, io_o, io_oe, io_i : flash pins (tristate resolved outside)
module qspi_master_ctrl
   import qspi_pkg::*;
#(
   parameter int CLK_DIV        = 2,
   parameter int DUMMY_CYCLES   = 4,
   parameter int CS_HIGH_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  opcode,
   input  logic [23:0] address,
   input  logic [7:0]  write_data,
   input  logic [3:0]  burst_len,
   output logic        wr_req,
   output logic        busy,
   output logic        done,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        CS,
   output logic        SCLK,
   output logic [3:0]  io_o,
   output logic [3:0]  io_oe,
   input  logic [3:0]  io_i
);
   localparam int MAXP = (DUMMY_CYCLES > CMD_PERIODS) ? DUMMY_CYCLES : CMD_PERIODS;
   localparam int PCW  = (MAXP > 1) ? $clog2(MAXP) : 1;
   localparam int HW   = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;

   qspi_state_e    state, state_n;
   logic [PCW-1:0] per_cnt, per_n;
   logic [4:0]     byte_cnt, byte_n;
   logic [HW-1:0]  hold_cnt, hold_n;
   logic [31:0]    shreg, sh_n;      // {opcode, address}, shifted out MSB first
   logic [7:0]     wbyte, wbyte_n;
   logic [3:0]     blen, blen_n;
   logic [3:0]     rd_hi, rd_hi_n;
   logic           is_wr, is_wr_n, is_rd, is_rd_n;
   logic           cs_n, busy_n, done_n, wr_req_n, rd_valid_n;
   logic [7:0]     rd_data_n;
   logic [3:0]     io_o_n, io_oe_n;
   logic           run, low_start, rise, pre_low, last_byte;

   assign run       = (state != IDLE) && (state != CS_HOLD);
   // 5-bit compare so burst_len=15 (16 bytes) cannot wrap.
   assign last_byte = (byte_cnt + 5'd1) == ({1'b0, blen} + 5'd1);

   qspi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .clk       (clk),
      .reset_n   (reset_n),
      .run       (run),
      .sclk      (SCLK),
      .low_start (low_start),
      .rise      (rise),
      .pre_low   (pre_low)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         per_cnt  <= '0;
         byte_cnt <= '0;
         hold_cnt <= '0;
         shreg    <= '0;
         wbyte    <= '0;
         blen     <= '0;
         rd_hi    <= '0;
         is_wr    <= 1'b0;
         is_rd    <= 1'b0;
         CS       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         wr_req   <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         io_o     <= '0;
         io_oe    <= '0;
      end else begin
         state    <= state_n;
         per_cnt  <= per_n;
         byte_cnt <= byte_n;
         hold_cnt <= hold_n;
         shreg    <= sh_n;
         wbyte    <= wbyte_n;
         blen     <= blen_n;
         rd_hi    <= rd_hi_n;
         is_wr    <= is_wr_n;
         is_rd    <= is_rd_n;
         CS       <= cs_n;
         busy     <= busy_n;
         done     <= done_n;
         wr_req   <= wr_req_n;
         rd_valid <= rd_valid_n;
         rd_data  <= rd_data_n;
         io_o     <= io_o_n;
         io_oe    <= io_oe_n;
      end
   end

   always_comb begin
      state_n    = state;
      per_n      = per_cnt;
      byte_n     = byte_cnt;
      hold_n     = hold_cnt;
      sh_n       = shreg;
      wbyte_n    = wbyte;
      blen_n     = blen;
      rd_hi_n    = rd_hi;
      is_wr_n    = is_wr;
      is_rd_n    = is_rd;
      cs_n       = CS;
      busy_n     = busy;
      done_n     = 1'b0;
      wr_req_n   = 1'b0;
      rd_valid_n = 1'b0;
      rd_data_n  = rd_data;
      io_o_n     = io_o;
      io_oe_n    = io_oe;

      case (state)
         IDLE: if (start) begin
            state_n = CMD;
            sh_n    = {opcode, address};
            wbyte_n = write_data;
            blen_n  = burst_len;
            is_wr_n = (opcode == OP_QPP);
            is_rd_n = (opcode == OP_QIOR);
            per_n   = '0;
            byte_n  = '0;
            cs_n    = 1'b0;
            busy_n  = 1'b1;
            io_oe_n = OE_SINGLE;
            io_o_n  = {3'b000, opcode[7]};
         end
         CMD: if (low_start) begin
            sh_n = shreg << 1;
            if (per_cnt == PCW'(CMD_PERIODS - 1)) begin
               per_n = '0;
               if (is_wr || is_rd) begin
                  state_n = ADDR;
                  io_oe_n = OE_QUAD;
                  io_o_n  = sh_n[31:28];
               end else begin
                  state_n = CS_HOLD;
                  hold_n  = '0;
                  cs_n    = 1'b1;
                  io_oe_n = OE_NONE;
                  io_o_n  = '0;
               end
            end else begin
               per_n  = per_cnt + PCW'(1);
               io_o_n = {3'b000, sh_n[31]};
            end
         end
         ADDR: if (low_start) begin
            if (per_cnt == PCW'(ADDR_PERIODS - 1)) begin
               per_n = '0;
               if (is_wr) begin
                  state_n = WDATA;
                  io_o_n  = wbyte[7:4];
               end else begin
                  state_n = DUMMY;
                  io_oe_n = OE_NONE;
                  io_o_n  = '0;
               end
            end else begin
               per_n  = per_cnt + PCW'(1);
               sh_n   = shreg << 4;
               io_o_n = sh_n[31:28];
            end
         end
         DUMMY: if (low_start) begin
            if (per_cnt == PCW'(DUMMY_CYCLES - 1)) begin
               per_n   = '0;
               state_n = RDATA;
            end else begin
               per_n = per_cnt + PCW'(1);
            end
         end
         WDATA: begin
            // Request the next byte in the final clk of the low-nibble period.
            if (pre_low && per_cnt[0] && !last_byte) wr_req_n = 1'b1;
            if (low_start) begin
               if (!per_cnt[0]) begin
                  per_n  = PCW'(1);
                  io_o_n = wbyte[3:0];
               end else if (last_byte) begin
                  state_n = CS_HOLD;
                  hold_n  = '0;
                  cs_n    = 1'b1;
                  io_oe_n = OE_NONE;
                  io_o_n  = '0;
               end else begin
                  per_n   = '0;
                  byte_n  = byte_cnt + 5'd1;
                  wbyte_n = write_data;
                  io_o_n  = write_data[7:4];
               end
            end
         end
         RDATA: begin
            if (rise) begin
               if (!per_cnt[0]) begin
                  rd_hi_n = io_i;
               end else begin
                  rd_data_n  = {rd_hi, io_i};
                  rd_valid_n = 1'b1;
               end
            end
            if (low_start) begin
               if (!per_cnt[0]) begin
                  per_n = PCW'(1);
               end else if (last_byte) begin
                  state_n = CS_HOLD;
                  hold_n  = '0;
                  cs_n    = 1'b1;
                  io_oe_n = OE_NONE;
                  io_o_n  = '0;
               end else begin
                  per_n  = '0;
                  byte_n = byte_cnt + 5'd1;
               end
            end
         end
         CS_HOLD: begin
            if (hold_cnt == HW'(CS_HIGH_CYCLES - 1)) begin
               state_n = IDLE;
               done_n  = 1'b1;
               busy_n  = 1'b0;
            end else begin
               hold_n = hold_cnt + HW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_qspi_master_ctrl.sv
// tb_qspi_master_ctrl: directed bench for qspi_master_ctrl (CLK_DIV=2,
// DUMMY_CYCLES=4, CS_HIGH_CYCLES=4). A per-clk monitor records the IO value
// at every SCLK rise, answers wr_req, plays slave read nibbles and counts
// strobes; each test task compares the record with hand-derived values.
module tb_qspi_master_ctrl;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  opcode = '0;
   logic [23:0] address = '0;
   logic [7:0]  write_data = '0;
   logic [3:0]  burst_len = '0;
   logic [3:0]  io_i = '0;
   logic        wr_req, busy, done, rd_valid, CS, SCLK;
   logic [7:0]  rd_data;
   logic [3:0]  io_o, io_oe;

   int checks = 0;
   int errors = 0;

   int          cs_low, rises, wr_cnt, rdv_cnt, done_cnt, cs_rise_c, done_c, rd_n;
   bit          got_done;
   logic [7:0]  rd_last;
   logic [3:0]  rio [64];
   logic [3:0]  roe [64];
   logic [7:0]  wr_bytes [16];
   logic [3:0]  rd_nibs [32];

   qspi_master_ctrl #(.CLK_DIV(2), .DUMMY_CYCLES(4), .CS_HIGH_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .address(address),
      .write_data(write_data), .burst_len(burst_len), .wr_req(wr_req), .busy(busy),
      .done(done), .rd_data(rd_data), .rd_valid(rd_valid), .CS(CS), .SCLK(SCLK),
      .io_o(io_o), .io_oe(io_oe), .io_i(io_i)
   );

   always #5 clk = ~clk;

   // Launch (optionally) and observe one frame until done or abort.
   task automatic run_frame(input logic [7:0] op, input logic [23:0] ad, input logic [3:0] bl,
                            input bit issue, input bit spam, input bit chain, input int abort_at);
      int   wptr;
      logic prev_sclk, prev_cs;
      cs_low = 0; rises = 0; wr_cnt = 0; rdv_cnt = 0; done_cnt = 0;
      cs_rise_c = -1; done_c = -1; got_done = 1'b0; rd_last = '0;
      if (issue) begin
         @(negedge clk);
         opcode = op; address = ad; burst_len = bl; write_data = wr_bytes[0]; start = 1'b1;
      end
      wptr = 1; prev_sclk = 1'b0; prev_cs = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (spam && busy && (c % 5 == 2)) start = 1'b1;
         if (!CS) cs_low++;
         if (!prev_cs && CS) cs_rise_c = c;
         if (SCLK && !prev_sclk) begin
            if (rises < 64) begin
               rio[rises] = io_o;
               roe[rises] = io_oe;
            end
            rises++;
            if (rises >= 18 && rises - 18 < rd_n) io_i = rd_nibs[rises-18];
            else io_i = 4'h0;
         end
         if (wr_req) begin
            wr_cnt++;
            if (wptr < 16) write_data = wr_bytes[wptr];
            wptr++;
         end
         if (rd_valid) begin
            rdv_cnt++;
            rd_last = rd_data;
         end
         if (abort_at > 0 && rises == abort_at) begin
            reset_n = 1'b0;
            break;
         end
         if (done) begin
            got_done = 1'b1;
            done_cnt++;
            done_c = c;
            if (chain) start = 1'b1;
            break;
         end
         prev_sclk = SCLK;
         prev_cs = CS;
      end
      if (abort_at == 0) begin
         checks++;
         if (!got_done) begin
            errors++;
            $display("FAIL frame_timeout: done not seen within 4000 clk");
         end
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({CS, SCLK, io_o, io_oe, busy, done, wr_req, rd_valid, rd_data} !== {1'b1, 1'b0, 4'h0, 4'h0, 4'b0000, 8'h00}) begin
         errors++;
         $display("FAIL reset_outputs: got CS=%b SCLK=%b io_o=%h io_oe=%h busy=%b done=%b wr_req=%b rd_valid=%b rd_data=%h, want CS=1 others 0",
                  CS, SCLK, io_o, io_oe, busy, done, wr_req, rd_valid, rd_data);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_cmd_only;
      logic [7:0] ob;
      ob = 8'h06;
      rd_n = 0;
      run_frame(8'h06, 24'h0, 4'h0, 1'b1, 1'b0, 1'b0, 0);
      checks++;
      if (cs_low !== 32) begin errors++; $display("FAIL cmd_cs_low: got %0d want 32", cs_low); end
      checks++;
      if (rises !== 8) begin errors++; $display("FAIL cmd_rises: got %0d want 8", rises); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({roe[i], rio[i]} !== {4'b0001, 3'b000, ob[7-i]}) begin
            errors++;
            $display("FAIL cmd_bit%0d: got oe=%b io=%b want oe=0001 io=000%b", i, roe[i], rio[i], ob[7-i]);
         end
      end
      checks++;
      if (done_c - cs_rise_c !== 4) begin errors++; $display("FAIL cmd_done_delay: got %0d want 4", done_c - cs_rise_c); end
      checks++;
      if (busy !== 1'b0 || wr_cnt !== 0) begin errors++; $display("FAIL cmd_busy_wr: got busy=%b wr=%0d want 0 0", busy, wr_cnt); end
   endtask

   task automatic test_qpp;
      logic [7:0] ob;
      logic [3:0] en [10];
      ob = 8'h38;
      en = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'h5, 4'h3, 4'hC};
      wr_bytes[0] = 8'hA5; wr_bytes[1] = 8'h3C;
      rd_n = 0;
      run_frame(8'h38, 24'h123456, 4'h1, 1'b1, 1'b0, 1'b0, 0);
      checks++;
      if (cs_low !== 72) begin errors++; $display("FAIL qpp_cs_low: got %0d want 72", cs_low); end
      checks++;
      if (wr_cnt !== 1) begin errors++; $display("FAIL qpp_wr_req: got %0d want 1", wr_cnt); end
      checks++;
      if (rises !== 18) begin errors++; $display("FAIL qpp_rises: got %0d want 18", rises); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({roe[i], rio[i]} !== {4'b0001, 3'b000, ob[7-i]}) begin
            errors++;
            $display("FAIL qpp_cmd_bit%0d: got oe=%b io=%b want io bit %b", i, roe[i], rio[i], ob[7-i]);
         end
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if ({roe[8+i], rio[8+i]} !== {4'hF, en[i]}) begin
            errors++;
            $display("FAIL qpp_nibble%0d: got oe=%h io=%h want oe=f io=%h", i, roe[8+i], rio[8+i], en[i]);
         end
      end
   endtask

   task automatic test_qpp_burst16;
      for (int b = 0; b < 16; b++) wr_bytes[b] = {4'(b), ~4'(b)};
      rd_n = 0;
      run_frame(8'h38, 24'hABCDEF, 4'hF, 1'b1, 1'b0, 1'b0, 0);
      checks++;
      if (wr_cnt !== 15) begin errors++; $display("FAIL burst_wr_req: got %0d want 15", wr_cnt); end
      checks++;
      if (rises !== 46) begin errors++; $display("FAIL burst_rises: got %0d want 46", rises); end
      checks++;
      if (cs_low !== 184) begin errors++; $display("FAIL burst_cs_low: got %0d want 184", cs_low); end
      for (int b = 0; b < 16; b++) begin
         checks++;
         if ({rio[14+2*b], rio[15+2*b]} !== {4'(b), ~4'(b)}) begin
            errors++;
            $display("FAIL burst_byte%0d: got %h%h want %h%h", b, rio[14+2*b], rio[15+2*b], 4'(b), ~4'(b));
         end
      end
   endtask

   task automatic test_qior;
      logic [3:0] an [6];
      an = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
      rd_nibs[0] = 4'h5; rd_nibs[1] = 4'hA; rd_n = 2;
      run_frame(8'hEB, 24'h000010, 4'h0, 1'b1, 1'b0, 1'b0, 0);
      checks++;
      if (rdv_cnt !== 1 || rd_last !== 8'h5A) begin
         errors++; $display("FAIL qior_read: got %0d pulses data=%h want 1 pulse 5a", rdv_cnt, rd_last);
      end
      checks++;
      if (rises !== 20 || cs_low !== 80) begin
         errors++; $display("FAIL qior_len: got rises=%0d cs_low=%0d want 20 80", rises, cs_low);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({roe[8+i], rio[8+i]} !== {4'hF, an[i]}) begin
            errors++; $display("FAIL qior_addr%0d: got oe=%h io=%h want f %h", i, roe[8+i], rio[8+i], an[i]);
         end
      end
      for (int i = 14; i < 20; i++) begin
         checks++;
         if (roe[i] !== 4'h0) begin errors++; $display("FAIL qior_oe_rise%0d: got %h want 0", i, roe[i]); end
      end
      checks++;
      if (wr_cnt !== 0) begin errors++; $display("FAIL qior_wr_req: got %0d want 0", wr_cnt); end
   endtask

   task automatic test_back_to_back;
      int extra_done, extra_cs;
      rd_nibs[0] = 4'hC; rd_nibs[1] = 4'h3; rd_n = 2;
      run_frame(8'hEB, 24'h00ABCD, 4'h0, 1'b1, 1'b1, 1'b0, 0);
      checks++;
      if (done_cnt !== 1 || rd_last !== 8'hC3) begin
         errors++; $display("FAIL spam_frame: got done=%0d data=%h want 1 c3", done_cnt, rd_last);
      end
      extra_done = 0; extra_cs = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) extra_done++;
         if (!CS) extra_cs++;
      end
      checks++;
      if (extra_done !== 0 || extra_cs !== 0) begin
         errors++; $display("FAIL spam_idle: got extra done=%0d cs_low=%0d want 0 0", extra_done, extra_cs);
      end
      rd_nibs[0] = 4'h5; rd_nibs[1] = 4'hA;
      run_frame(8'hEB, 24'h000010, 4'h0, 1'b1, 1'b0, 1'b1, 0);
      rd_nibs[0] = 4'h9; rd_nibs[1] = 4'h6;
      run_frame(8'hEB, 24'h000010, 4'h0, 1'b0, 1'b0, 1'b0, 0);
      checks++;
      if (rd_last !== 8'h96 || rdv_cnt !== 1) begin
         errors++; $display("FAIL chain_read: got %0d pulses data=%h want 1 96", rdv_cnt, rd_last);
      end
      checks++;
      if (cs_low !== 80) begin errors++; $display("FAIL chain_cs_low: got %0d want 80", cs_low); end
   endtask

   task automatic test_reset_mid_frame;
      int extra_done;
      wr_bytes[0] = 8'hA5; wr_bytes[1] = 8'h3C; rd_n = 0;
      run_frame(8'h38, 24'h123456, 4'h1, 1'b1, 1'b0, 1'b0, 10);
      @(negedge clk);
      checks++;
      if ({CS, SCLK, io_oe, busy, done} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL abort_state: got CS=%b SCLK=%b io_oe=%h busy=%b done=%b want 1 0 0 0 0", CS, SCLK, io_oe, busy, done);
      end
      reset_n = 1'b1;
      extra_done = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      checks++;
      if (extra_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", extra_done); end
      rd_nibs[0] = 4'h3; rd_nibs[1] = 4'hC; rd_n = 2;
      run_frame(8'hEB, 24'h000010, 4'h0, 1'b1, 1'b0, 1'b0, 0);
      checks++;
      if (rd_last !== 8'h3C || cs_low !== 80 || rdv_cnt !== 1) begin
         errors++; $display("FAIL abort_recover: got data=%h cs_low=%0d pulses=%0d want 3c 80 1", rd_last, cs_low, rdv_cnt);
      end
   endtask

   initial begin
      test_reset;
      test_cmd_only;
      test_qpp;
      test_qpp_burst16;
      test_qior;
      test_back_to_back;
      test_reset_mid_frame;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
